// File: rtl/fixed_mult_seq.sv
// Sequential signed fixed-point multiplier.
// Takes two WIDTH-bit two's-complement operands and returns the exact 2*WIDTH-bit product.
// Works on magnitudes with a radix-2 shift-add loop, one iteration per cycle.
// The sign is applied when the result is registered.
module fixed_mult_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;    // |a|
    logic [WIDTH-1:0]  mplier_q, mplier_d;  // |b|, consumed LSB first
    logic [PW:0]       acc_q, acc_d;        // one spare bit catches the add carry
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              sign_q, sign_d;
    logic [PW-1:0]     product_q, product_d;

    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH:0]    upper_sum;
    logic [PW-1:0]     mag;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            product_q <= product_d;
        end
    end

    // Next-state, datapath and handshake outputs
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        product_d = product_q;

        // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is correct unsigned.
        a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
        b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

        upper_sum = acc_q[PW:WIDTH] + {1'b0, (mplier_q[0] ? mcand_q : '0)};
        mag       = '0;

        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                busy     = 1'b1;
                acc_d    = {1'b0, upper_sum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    mag       = acc_d[PW-1:0];
                    // Two's-complement negation of zero stays zero.
                    product_d = sign_q ? (~mag + PW'(1)) : mag;
                    state_d   = StDone;
                end
            end
            StDone: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign product = product_q;

endmodule

// File: doc/fixed_mult_seq.md
# fixed_mult_seq

Sequential signed fixed-point multiplier that produces the full-precision 64-bit products consumed by the 64→32 rounding stage. It sits on the producer side of that interface and runs ahead of the rounder in the datapath. It accepts two 32-bit two's-complement operands over a valid/ready handshake and computes the exact product with a radix-2 shift-add loop. It returns the product over a second valid/ready handshake.

## Interface
Parameters:
- WIDTH, 32: operand width. Product width is 2*WIDTH. The iteration count equals WIDTH.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operands a, b are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  multiplicand, two's complement (Q16.16 in the NN datapath).
- b  input  WIDTH  multiplier, two's complement.
- out_valid  output  1  product is valid; high only in DONE.
- out_ready  input  1  downstream accepts the product.
- product  output  2*WIDTH  exact two's-complement a*b. Binary point is at twice the operand point, e.g. Q32.32.
- busy  output  1  high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE. Reset forces IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, register the following, then go to CALC:
    - |a| and |b| as WIDTH-bit unsigned values. Magnitude of 0x8000_0000 is 2^31, which is representable.
    - sign = a[MSB] ^ b[MSB].
    - Accumulator cleared, iteration counter = 0.
- CALC, one iteration per cycle:
  - If bit 0 of the multiplier shift register is 1, add |a| into the upper half of a 2*WIDTH+1-bit accumulator.
  - Shift the accumulator and the multiplier right by 1; increment the counter.
  - After the WIDTH-th iteration, go to DONE.
  - On the same edge, register product = sign ? -mag : mag, where mag is the 2*WIDTH-bit magnitude.
- DONE:
  - out_valid=1; product held stable.
  - On out_ready, go to IDLE.
  - in_ready stays 0 during DONE, so a new operand cannot be accepted in the same cycle as the output transfer.
- Arithmetic:
  - The product is exact; no rounding, truncation or saturation.
  - The largest magnitude is 2^62 (both operands 0x8000_0000). It fits as a positive 64-bit signed value.
  - Negating a zero magnitude yields 0; -0 is never produced.
- in_valid outside IDLE is ignored. Operand inputs are not sampled except at the accept edge.
- product register is written only at the CALC→DONE edge. It keeps its value after returning to IDLE until the next result.

## Timing
- Reset values, in effect at the first rising edge with rst_n=0:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - product=0, accumulator=0, counter=0.
- Reset priority: rst_n=0 overrides every other input in any state. Reset mid-CALC or mid-DONE discards the operation; no out_valid pulse follows.
- Latency: accept at edge E0, CALC occupies edges E1..E32, and out_valid goes high after E32. That is 32 cycles from accept to out_valid.
- Transfer: the output transfers at the first edge where out_valid && out_ready. in_ready rises the cycle after.
- Minimum cycle period per operation: 34 edges (accept, 32 CALC, 1 DONE with out_ready already high).
- Back-pressure: out_valid and product remain constant for any number of cycles while out_ready=0.
- out_ready while not in DONE has no effect.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, busy=0, product=0, in_ready=1 after release; no operation started.
- Positive: a=0x0001_8000 (1.5), b=0x0002_0000 (2.0), out_ready=1 → out_valid exactly 32 cycles after accept, product=0x0000_0003_0000_0000; IDLE one cycle later.
- Mixed sign and zero:
  - a=0xFFFF_0000 (-1.0), b=0x0003_0000 → product=0xFFFF_FFFD_0000_0000.
  - a=0xFFFF_0000, b=0 → product=0.
- Extremes: a=b=0x8000_0000 → 0x4000_0000_0000_0000. a=0x8000_0000, b=0x7FFF_FFFF → 0xC000_0000_8000_0000.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid while pulsing in_valid with new operands → product unchanged, in_ready=0, new operands ignored. Raise out_ready → IDLE next cycle, then the next operation completes correctly.
- Reset mid-operation: assert rst_n=0 for one edge at CALC iteration 10 → IDLE and busy=0 after that edge, out_valid never asserts. A following 3.0×3.0 (0x0003_0000 each) gives 0x0000_0009_0000_0000.
